// File: rtl/program_loader.sv
// Boot loader: receives a framed program image byte stream, writes little-endian
// words to instruction memory, and releases the processor once the checksum matches.
module program_loader #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  reset_i,
    input  logic [7:0]            rx_data_i,
    input  logic                  rx_valid_i,
    output logic                  rx_ready_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [31:0]           mem_data_o,
    output logic                  mem_we_o,
    output logic                  cpu_reset_o,
    output logic                  done_o,
    output logic                  error_o
);

    typedef enum logic [2:0] {
        HDR_LO,
        HDR_HI,
        DATA,
        CSUM,
        RUN,
        ERROR
    } state_t;

    localparam logic [16:0] CAPACITY = 17'd1 << ADDR_WIDTH;

    state_t                state_reg;
    logic [15:0]           count_reg;
    logic [ADDR_WIDTH:0]   word_idx_reg;
    logic [1:0]            lane_reg;
    logic [7:0]            sum_reg;
    logic [23:0]           word_buf_reg;

    logic                  accept;
    logic [16:0]           hdr_count;
    logic [16:0]           words_done;

    // rx_ready_o is only high in loading states, so it gates every transfer.
    assign accept     = rx_valid_i & rx_ready_o;
    assign hdr_count  = {1'b0, rx_data_i, count_reg[7:0]};
    assign words_done = 17'(word_idx_reg) + 17'd1;

    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            state_reg    <= HDR_LO;
            count_reg    <= '0;
            word_idx_reg <= '0;
            lane_reg     <= '0;
            sum_reg      <= '0;
            word_buf_reg <= '0;
            rx_ready_o   <= 1'b0;
            mem_addr_o   <= '0;
            mem_data_o   <= '0;
            mem_we_o     <= 1'b0;
            cpu_reset_o  <= 1'b1;
            done_o       <= 1'b0;
            error_o      <= 1'b0;
        end else begin
            mem_we_o <= 1'b0;
            case (state_reg)
                HDR_LO: begin
                    rx_ready_o <= 1'b1;
                    if (accept) begin
                        count_reg[7:0] <= rx_data_i;
                        state_reg      <= HDR_HI;
                    end
                end
                HDR_HI: begin
                    rx_ready_o <= 1'b1;
                    if (accept) begin
                        count_reg[15:8] <= rx_data_i;
                        if (hdr_count > CAPACITY) begin
                            state_reg  <= ERROR;
                            error_o    <= 1'b1;
                            rx_ready_o <= 1'b0;
                        end else if (hdr_count == 17'd0) begin
                            state_reg <= CSUM;
                        end else begin
                            state_reg <= DATA;
                        end
                    end
                end
                DATA: begin
                    rx_ready_o <= 1'b1;
                    if (accept) begin
                        sum_reg <= sum_reg + rx_data_i;
                        if (lane_reg == 2'd3) begin
                            mem_we_o     <= 1'b1;
                            mem_addr_o   <= word_idx_reg[ADDR_WIDTH-1:0];
                            mem_data_o   <= {rx_data_i, word_buf_reg};
                            lane_reg     <= 2'd0;
                            word_idx_reg <= words_done[ADDR_WIDTH:0];
                            if (words_done == {1'b0, count_reg})
                                state_reg <= CSUM;
                        end else begin
                            word_buf_reg[{lane_reg, 3'b000} +: 8] <= rx_data_i;
                            lane_reg <= lane_reg + 2'd1;
                        end
                    end
                end
                CSUM: begin
                    rx_ready_o <= 1'b1;
                    if (accept) begin
                        rx_ready_o <= 1'b0;
                        if (rx_data_i == sum_reg) begin
                            state_reg   <= RUN;
                            cpu_reset_o <= 1'b0;
                            done_o      <= 1'b1;
                        end else begin
                            state_reg <= ERROR;
                            error_o   <= 1'b1;
                        end
                    end
                end
                RUN, ERROR: begin
                    rx_ready_o <= 1'b0;
                end
                default: begin
                    state_reg  <= HDR_LO;
                    rx_ready_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Drives the same byte stream into a full-size and a 4-word loader and checks both
// against a frame-level model of what each should write and report.
module tb_program_loader;

    logic        clk = 1'b0;
    logic        reset_i;
    logic [7:0]  rx_data;
    logic        rx_valid;

    logic        ready_a, we_a, cpu_rst_a, done_a, err_a;
    logic [9:0]  addr_a;
    logic [31:0] data_a;
    logic        ready_b, we_b, cpu_rst_b, done_b, err_b;
    logic [1:0]  addr_b;
    logic [31:0] data_b;

    always #5 clk = ~clk;

    program_loader #(.ADDR_WIDTH(10)) dut_a (
        .clk(clk), .reset_i(reset_i), .rx_data_i(rx_data), .rx_valid_i(rx_valid),
        .rx_ready_o(ready_a), .mem_addr_o(addr_a), .mem_data_o(data_a), .mem_we_o(we_a),
        .cpu_reset_o(cpu_rst_a), .done_o(done_a), .error_o(err_a)
    );

    program_loader #(.ADDR_WIDTH(2)) dut_b (
        .clk(clk), .reset_i(reset_i), .rx_data_i(rx_data), .rx_valid_i(rx_valid),
        .rx_ready_o(ready_b), .mem_addr_o(addr_b), .mem_data_o(data_b), .mem_we_o(we_b),
        .cpu_reset_o(cpu_rst_b), .done_o(done_b), .error_o(err_b)
    );

    int total = 0;
    int passed = 0;

    int unsigned addr_a_q[$], data_a_q[$], addr_b_q[$], data_b_q[$];
    logic [31:0] pay_q[$];

    // Collect every write strobe mid-cycle.
    always @(negedge clk) begin
        if (we_a) begin
            addr_a_q.push_back(32'(addr_a));
            data_a_q.push_back(data_a);
        end
        if (we_b) begin
            addr_b_q.push_back(32'(addr_b));
            data_b_q.push_back(data_b);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [7:0] pay_sum();
        logic [7:0] s = 8'd0;
        foreach (pay_q[i])
            s = s + pay_q[i][7:0] + pay_q[i][15:8] + pay_q[i][23:16] + pay_q[i][31:24];
        return s;
    endfunction

    task automatic clear_log();
        addr_a_q.delete(); data_a_q.delete(); addr_b_q.delete(); data_b_q.delete();
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        rx_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_i = 1'b0;
        @(posedge clk);
        #1;
        clear_log();
    endtask

    // One byte offered with valid high across one edge; optional idle cycle after it.
    task automatic send(input logic [7:0] b, input bit gap);
        rx_data = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1 rx_valid = 1'b0;
        if (gap) begin
            rx_data = 8'($urandom);
            @(posedge clk);
            #1;
        end
    endtask

    // gap_mode: 0 back-to-back, 1 idle after every byte, 2 random idles.
    task automatic send_frame(input int n_field, input logic [7:0] csum, input int gap_mode);
        bit g;
        g = (gap_mode == 1) || (gap_mode == 2 && $urandom_range(0, 1) == 1);
        send(8'(n_field), g);
        g = (gap_mode == 1) || (gap_mode == 2 && $urandom_range(0, 1) == 1);
        send(8'(n_field >> 8), g);
        foreach (pay_q[i]) begin
            for (int k = 0; k < 4; k++) begin
                g = (gap_mode == 1) || (gap_mode == 2 && $urandom_range(0, 1) == 1);
                send(pay_q[i][8*k +: 8], g);
            end
        end
        send(csum, 1'b0);
    endtask

    // Expected outcome: an oversize count is rejected with no writes; otherwise every
    // word lands at its index and the checksum decides between RUN and ERROR.
    task automatic check_load(input string tag, input int n_field, input logic [7:0] csum);
        for (int d = 0; d < 2; d++) begin
            int    cap = (d == 0) ? 1024 : 4;
            string sfx = (d == 0) ? "/aw10" : "/aw2";
            bit    ok_len = (n_field <= cap);
            int    nw = ok_len ? n_field : 0;
            bit    exp_done = ok_len && (csum == pay_sum());
            int    got = (d == 0) ? addr_a_q.size() : addr_b_q.size();
            check({tag, sfx, " nwrites"}, 32'(got), 32'(nw));
            for (int i = 0; i < nw && i < got; i++) begin
                check($sformatf("%s%s addr[%0d]", tag, sfx, i),
                      (d == 0) ? addr_a_q[i] : addr_b_q[i], 32'(i));
                check($sformatf("%s%s data[%0d]", tag, sfx, i),
                      (d == 0) ? data_a_q[i] : data_b_q[i], pay_q[i]);
            end
            check({tag, sfx, " done"},    32'((d == 0) ? done_a : done_b), 32'(exp_done));
            check({tag, sfx, " error"},   32'((d == 0) ? err_a : err_b), 32'(!exp_done));
            check({tag, sfx, " cpu_rst"}, 32'((d == 0) ? cpu_rst_a : cpu_rst_b), 32'(!exp_done));
            check({tag, sfx, " ready"},   32'((d == 0) ? ready_a : ready_b), 32'd0);
        end
    endtask

    initial begin
        rx_data = 8'h00;
        rx_valid = 1'b0;

        // Reset state and release timing.
        reset_i = 1'b1;
        #1;
        check("rst ready", 32'(ready_a), 32'd0);
        check("rst cpu_rst", 32'(cpu_rst_a), 32'd1);
        check("rst done/err/we", {29'd0, done_a, err_a, we_a}, 32'd0);
        check("rst addr/data", data_a | 32'(addr_a), 32'd0);
        @(posedge clk);
        #1 reset_i = 1'b0;
        #3;
        check("ready before edge", 32'(ready_a), 32'd0);
        @(posedge clk);
        #1;
        check("ready after release", 32'(ready_a), 32'd1);
        repeat (5) @(posedge clk);
        #1;
        check("idle no writes", 32'(addr_a_q.size() + addr_b_q.size()), 32'd0);
        check("idle cpu_rst", 32'(cpu_rst_a), 32'd1);
        clear_log();

        // Single word, back-to-back, with write and RUN timing checked cycle-exactly.
        pay_q = '{32'h12345678};
        send(8'h01, 0); send(8'h00, 0);
        send(8'h78, 0); send(8'h56, 0); send(8'h34, 0); send(8'h12, 0);
        check("w1 we", 32'(we_a), 32'd1);
        check("w1 addr", 32'(addr_a), 32'd0);
        check("w1 data", data_a, 32'h12345678);
        send(8'h14, 0);
        check("w1 done now", 32'(done_a), 32'd1);
        check("w1 we after", 32'(we_a), 32'd0);
        check("w1 data held", data_a, 32'h12345678);
        check_load("one word", 1, 8'h14);

        // Two words with valid toggling, then bad checksum plus ignored trailing bytes.
        do_reset();
        pay_q = '{32'h04030201, 32'h08070605};
        send_frame(2, 8'h24, 1);
        check_load("two words", 2, 8'h24);
        do_reset();
        send_frame(2, 8'h25, 1);
        repeat (4) send(8'($urandom), 0);
        check_load("bad csum", 2, 8'h25);

        // Length 5: only the 4-word loader rejects it, at the N_HI edge.
        do_reset();
        pay_q = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 32'h55555555};
        send(8'h05, 0); send(8'h00, 0);
        check("len err aw2", 32'(err_b), 32'd1);
        check("len ready aw2", 32'(ready_b), 32'd0);
        check("len ok aw10", {30'd0, err_a, ready_a}, 32'd1);
        foreach (pay_q[i]) for (int k = 0; k < 4; k++) send(pay_q[i][8*k +: 8], 0);
        send(pay_sum(), 0);
        check_load("len5", 5, pay_sum());

        // Exact fill of the 4-word memory, then empty image.
        do_reset();
        pay_q = '{32'hdeadbeef, 32'h01234567, 32'h89abcdef, 32'hfedcba98};
        send_frame(4, pay_sum(), 0);
        check_load("fill4", 4, pay_sum());
        do_reset();
        pay_q = '{};
        send_frame(0, 8'h00, 0);
        check_load("empty", 0, 8'h00);

        // Reset in the middle of a word, then a fresh frame.
        do_reset();
        send(8'h01, 0); send(8'h00, 0); send(8'haa, 0); send(8'hbb, 0); send(8'hcc, 0);
        reset_i = 1'b1;
        #1;
        check("midrst cpu_rst", 32'(cpu_rst_a), 32'd1);
        check("midrst ready", 32'(ready_a), 32'd0);
        repeat (2) @(posedge clk);
        #1 reset_i = 1'b0;
        @(posedge clk);
        #1;
        pay_q = '{32'hcafef00d};
        send_frame(1, pay_sum(), 2);
        check_load("after midrst", 1, pay_sum());

        // Random frames.
        for (int t = 0; t < 20; t++) begin
            int n = $urandom_range(0, 6);
            logic [7:0] cs;
            do_reset();
            pay_q = '{};
            for (int i = 0; i < n; i++) pay_q.push_back($urandom);
            cs = pay_sum() + (($urandom_range(0, 3) == 0) ? 8'd1 : 8'd0);
            send_frame(n, cs, 2);
            repeat (2) send(8'($urandom), 0);
            check_load($sformatf("rand%0d", t), n, cs);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/program_loader.md
# program_loader

Boot-time loader that sits upstream of the processor and its instruction memory. It receives a framed program image as a byte stream (valid/ready), assembles little-endian 32-bit words, and writes them to consecutive word addresses of the instruction memory. It holds the processor in reset until the whole image and its checksum have been accepted. On a checksum or length error it keeps the processor in reset and flags the error.

## Interface
- ADDR_WIDTH, 10: word-address width of instruction memory; capacity is 2^ADDR_WIDTH words.
- clk  in  1  single system clock, rising edge.
- reset_i  in  1  asynchronous, active-high reset.
- rx_data_i  in  8  incoming image byte.
- rx_valid_i  in  1  rx_data_i is valid.
- rx_ready_o  out  1  loader can accept a byte; a transfer occurs on an edge where rx_valid_i & rx_ready_o.
- mem_addr_o  out  ADDR_WIDTH  word address of the write.
- mem_data_o  out  32  assembled word.
- mem_we_o  out  1  one-cycle write strobe.
- cpu_reset_o  out  1  reset to the processor; high until a successful load.
- done_o  out  1  load completed and checksum OK.
- error_o  out  1  load aborted (bad length or bad checksum).

## Operation
- Frame format: N_LO, N_HI (16-bit word count N, little-endian), then 4·N payload bytes (each word LSB first), then CSUM.
- CSUM is the 8-bit modulo-256 sum of the payload bytes only. Header bytes are excluded.
- States:
  - HDR_LO: accept N_LO, then go to HDR_HI.
  - HDR_HI: accept N_HI. Then:
    - N > 2^ADDR_WIDTH: go to ERROR.
    - N = 0: go to CSUM.
    - otherwise: go to DATA.
  - DATA: accept bytes, shifting each into the word at byte lane (count mod 4).
    - After the 4th byte of a word, issue the write, clear the lane counter and increment the word index.
    - After word N-1 completes, go to CSUM.
  - CSUM: accept one byte. Equal to the running sum: go to RUN. Otherwise: go to ERROR.
  - RUN: terminal until reset.
  - ERROR: terminal until reset.
- rx_ready_o is 1 in HDR_LO, HDR_HI, DATA and CSUM, and 0 in RUN and ERROR.
- Outputs by state:
  - cpu_reset_o = 0 only in RUN.
  - done_o = 1 only in RUN.
  - error_o = 1 only in ERROR.
- The word index starts at 0 and is ADDR_WIDTH+1 bits wide internally.
  - mem_addr_o is its low ADDR_WIDTH bits.
  - N = 2^ADDR_WIDTH is legal and fills memory exactly. The index never wraps within a load.
- The running sum is 8-bit and wraps modulo 256. It is cleared on reset.
- Bytes presented while rx_ready_o = 0 are ignored and have no effect on state.
- Memory contents are never cleared by this block.

## Timing
- Reset values (asynchronous, while reset_i = 1):
  - state HDR_LO.
  - rx_ready_o 0, mem_we_o 0, mem_addr_o 0, mem_data_o 0.
  - cpu_reset_o 1, done_o 0, error_o 0.
  - word index 0, lane 0, sum 0.
- All outputs are registered.
  - rx_ready_o rises at the first rising edge after reset_i falls.
  - rx_ready_o falls at the same edge that enters RUN or ERROR.
- Write latency: the 4th byte of a word is accepted at edge k. mem_we_o is high for exactly the cycle between edges k and k+1, with mem_addr_o and mem_data_o valid in that cycle.
  - mem_addr_o and mem_data_o hold their values after the strobe.
- Throughput: one byte per cycle sustained. The write of the last word may share its cycle with acceptance of CSUM.
- CSUM is accepted at edge k. At that same edge cpu_reset_o and done_o (RUN), or error_o (ERROR), update, so they are visible in the cycle after edge k.
- A length error is flagged at the edge that accepts N_HI. No writes occur in that case.
- Reset asserted mid-load: all state clears immediately and cpu_reset_o returns to 1. After release, the next byte is treated as N_LO.

## Test plan
- Reset release, no traffic -> rx_ready_o 0 during reset and 1 one edge after release; cpu_reset_o 1, done_o 0, error_o 0, mem_we_o never pulses.
- Frame 01 00 78 56 34 12 14 at one byte per cycle -> one mem_we_o pulse with addr 0, data 0x12345678, the cycle after byte 0x12; done_o 1 and cpu_reset_o 0 after CSUM; rx_ready_o 0 thereafter.
- Frame 02 00 + 8 bytes 01..08 + CSUM 0x24, with rx_valid_i toggling every other cycle -> writes addr 0 = 0x04030201 and addr 1 = 0x08070605; done_o 1.
- Same two-word frame with CSUM 0x25 -> both writes occur, then error_o 1, cpu_reset_o stays 1, done_o 0; further bytes ignored.
- ADDR_WIDTH = 2, header 05 00 -> error_o 1 the cycle after N_HI, no writes. Header 04 00 + 16 bytes + correct CSUM -> writes to addresses 0..3, done_o 1.
- Header 00 00 followed by CSUM 00 -> done_o 1 with no writes. Separately, reset_i pulsed after 3 payload bytes of a 1-word frame, then a fresh full frame -> no write from the aborted frame; the fresh frame loads correctly.
